// File: rtl/npu_pkg.sv
// Shared types and helpers for the NPU convolution scan sequencer.
package npu_pkg;

  localparam int unsigned ACC_W = 24;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StClear  = 4'd1,
    StFetch  = 4'd2,
    StWait   = 4'd3,
    StCal    = 4'd4,
    StMinus  = 4'd5,
    StSettle = 4'd6,
    StOut    = 4'd7,
    StDone   = 4'd8
  } seq_state_e;

  // High when a result has to be clamped to zero; kept width-agnostic so any ACC_W can use it.
  function automatic logic relu(input logic en, input logic neg);
    return en & neg;
  endfunction

endpackage

// File: rtl/npu_addr_gen.sv
// Output-position and window-column counters for the conv sequencer; produces the image column
// address from an incrementally maintained row base.
module npu_addr_gen #(
  parameter int unsigned K_W    = 3,
  parameter int unsigned IN_W   = 15,
  parameter int unsigned OUT_H  = 14,
  parameter int unsigned OUT_W  = 13,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              k_step,
  input  logic              pix_step,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        row,
  output logic [7:0]        col,
  output logic              k_last,
  output logic              pix_last
);

  logic [7:0]        row_q;
  logic [7:0]        col_q;
  logic [7:0]        k_q;
  logic [ADDR_W-1:0] base_q;
  logic              row_last;
  logic              col_last;

  assign k_last   = (k_q == 8'(K_W - 1));
  assign col_last = (col_q == 8'(OUT_W - 1));
  assign row_last = (row_q == 8'(OUT_H - 1));
  assign pix_last = row_last && col_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= 8'd0;
      col_q  <= 8'd0;
      k_q    <= 8'd0;
      base_q <= '0;
    end else if (init) begin
      row_q  <= 8'd0;
      col_q  <= 8'd0;
      k_q    <= 8'd0;
      base_q <= '0;
    end else begin
      if (k_step) begin
        k_q <= k_last ? 8'd0 : k_q + 8'd1;
      end
      if (pix_step) begin
        if (!col_last) begin
          col_q <= col_q + 8'd1;
        end else begin
          col_q <= 8'd0;
          // Row base advances by one image row, so the address path needs adders only.
          if (row_last) begin
            row_q  <= 8'd0;
            base_q <= '0;
          end else begin
            row_q  <= row_q + 8'd1;
            base_q <= base_q + ADDR_W'(IN_W);
          end
        end
      end
    end
  end

  assign addr = base_q + ADDR_W'(col_q) + ADDR_W'(k_q);
  assign row  = row_q;
  assign col  = col_q;

endmodule

// File: rtl/npu_conv_seq.sv
// Convolution scan sequencer: one start pulse runs a whole layer pass over every output pixel.
// Optional stall counter enabled by defining NPU_CONV_SEQ_PERF_EN.
module npu_conv_seq #(
  parameter int unsigned K_H    = 3,
  parameter int unsigned K_W    = 3,
  parameter int unsigned IN_H   = 16,
  parameter int unsigned IN_W   = 15,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned ACC_W  = npu_pkg::ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    relu_en,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    img_rd_en,
  output logic [ADDR_W-1:0]       img_rd_addr,
  input  logic                    img_rd_valid,
  output logic                    img_ld,
  output logic                    w_shift,
  output logic                    pe_clear,
  output logic                    pe_trigger,
  output logic                    pe_minus,
  input  logic signed [ACC_W-1:0] pe_sum,
  output logic                    res_valid,
  output logic [ACC_W-1:0]        res_data,
  input  logic                    res_ready,
  output logic [7:0]              out_row,
  output logic [7:0]              out_col,
  output logic [31:0]             stall_cnt
);
  import npu_pkg::*;

  localparam int unsigned OUT_H = IN_H - K_H + 1;
  localparam int unsigned OUT_W = IN_W - K_W + 1;

  seq_state_e       state_q, state_d;
  logic             relu_q;
  logic [ACC_W-1:0] res_q;
  logic             go;
  logic             k_last;
  logic             pix_last;

  assign go = (state_q == StIdle) && start && !abort;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StClear;
      StClear:  state_d = StFetch;
      StFetch:  state_d = StWait;
      StWait:   if (img_rd_valid) state_d = StCal;
      StCal:    state_d = StMinus;
      StMinus:  state_d = k_last ? StSettle : StFetch;
      StSettle: state_d = StOut;
      StOut:    if (res_ready) state_d = pix_last ? StDone : StClear;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      relu_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (go) relu_q <= relu_en;
      if (state_q == StSettle) begin
        res_q <= relu(relu_q, pe_sum[ACC_W-1]) ? '0 : pe_sum;
      end
    end
  end

  npu_addr_gen #(
    .K_W   (K_W),
    .IN_W  (IN_W),
    .OUT_H (OUT_H),
    .OUT_W (OUT_W),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .init    (go || abort),
    .k_step  (state_q == StMinus),
    .pix_step((state_q == StOut) && res_ready),
    .addr    (img_rd_addr),
    .row     (out_row),
    .col     (out_col),
    .k_last  (k_last),
    .pix_last(pix_last)
  );

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign pe_clear   = (state_q == StClear);
  assign img_rd_en  = (state_q == StFetch);
  assign pe_trigger = (state_q == StCal) || (state_q == StMinus);
  assign pe_minus   = (state_q == StMinus);
  assign w_shift    = (state_q == StMinus);
  assign res_valid  = (state_q == StOut);
  assign res_data   = res_q;
  // The only output with a combinational input path: load lands in the same cycle as the data.
  assign img_ld     = (state_q == StWait) && img_rd_valid;

`ifdef NPU_CONV_SEQ_PERF_EN
  logic [31:0] stall_q;
  logic        stall_ev;

  assign stall_ev = ((state_q == StWait) && !img_rd_valid) || ((state_q == StOut) && !res_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else if (go) begin
      stall_q <= 32'd0;
    end else if (stall_ev && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
